// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bundle.
// master: fetch side (req, addr out); slave: memory side (gnt, rvalid, rdata out).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch front end.
// Ports: clk, rst_n (sync, active-low); next_pc/pc_update from the
// sequencer; pc, pc_plus4 to it; imem bus (master); inst/inst_valid
// to decode; fetch_fault (sticky misaligned target); instret counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_update,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  fetch_unit_if.master imem,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        fault_q;
  logic        req_q;
  logic [31:0] instret_q;

  logic [31:0] instret_d;
  logic        aligned_d;

  assign instret_d = instret_q + 32'd1;
  assign aligned_d = (next_pc[1:0] == 2'b00);

  // All outputs are registered; req_q is set on entry to REQ so the
  // request appears in the cycle right after the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      req_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem.imem_gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state_q <= HOLD;
            inst_q  <= imem.imem_rdata;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // One retire per visit: leaving HOLD makes a held
          // pc_update inert until the next word arrives.
          if (pc_update) begin
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            instret_q <= instret_d;
            if (aligned_d) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          // Terminal until reset; pc keeps the bad target.
          req_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = valid_q;
  assign fetch_fault    = fault_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, retire, stalls,
// misaligned fault, reset mid-fetch and wrap-around.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_update;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_fault;
  logic [31:0] instret;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .pc_update  (pc_update),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .imem       (bus),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fetch_fault(fetch_fault),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assumes REQ with req high; gd gnt-low cycles, rd rvalid-low
  // cycles, with a stray pc_update pulse in the first WAIT cycle.
  task automatic fetch(input int gd, input int rd,
                       input logic [31:0] d);
    check("req_pre", bus.imem_req, 1'b1);
    check("addr_pre", bus.imem_addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      bus.imem_gnt = 1'b0;
      step();
      check("req_stall", bus.imem_req, 1'b1);
      check("addr_stall", bus.imem_addr, exp_pc);
    end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    check("req_drop", bus.imem_req, 1'b0);
    for (int i = 0; i < rd; i++) begin
      if (i == 0) begin
        pc_update = 1'b1;
        next_pc   = 32'h0000_0200;
      end
      step();
      pc_update = 1'b0;
      check("wait_valid", inst_valid, 1'b0);
      check("wait_pc", pc, exp_pc);
      check("wait_instret", instret, exp_instret);
      check("wait_req", bus.imem_req, 1'b0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = d;
    step();
    bus.imem_rvalid = 1'b0;
    check("valid", inst_valid, 1'b1);
    check("inst", inst, d);
    check("hold_pc", pc, exp_pc);
  endtask

  task automatic retire(input logic [31:0] npc);
    next_pc   = npc;
    pc_update = 1'b1;
    step();
    pc_update   = 1'b0;
    exp_instret = exp_instret + 32'd1;
    exp_pc      = npc;
    check("ret_pc", pc, npc);
    check("ret_instret", instret, exp_instret);
    check("ret_valid", inst_valid, 1'b0);
    if (npc[1:0] == 2'b00) begin
      check("ret_req", bus.imem_req, 1'b1);
      check("ret_addr", bus.imem_addr, npc);
      check("ret_fault", fetch_fault, 1'b0);
    end else begin
      check("ret_fault", fetch_fault, 1'b1);
      check("ret_req", bus.imem_req, 1'b0);
    end
  endtask

  task automatic reset_checks();
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);
    check("rst_instret", instret, 32'h0);
    check("rst_req", bus.imem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    n_chk           = 0;
    n_fail          = 0;
    exp_pc          = RST_PC;
    exp_instret     = 32'h0;
    rst_n           = 1'b0;
    next_pc         = 32'h0;
    pc_update       = 1'b0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // 1: reset and first fetch
    step();
    step();
    reset_checks();
    rst_n = 1'b1;
    step();
    fetch(0, 0, 32'h0050_0093);
    check("t1_plus4", pc_plus4, 32'h0000_0104);

    // stray response in HOLD is dropped
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hFFFF_FFFF;
    step();
    bus.imem_rvalid = 1'b0;
    check("stray_inst", inst, 32'h0050_0093);
    check("stray_valid", inst_valid, 1'b1);

    // 2: sequential then taken branch
    retire(32'h0000_0104);
    fetch(0, 0, 32'h0000_0013);
    retire(32'h0000_0040);

    // 3: memory stalls
    fetch(3, 4, 32'h1234_5678);

    // 4: misaligned target
    retire(32'h0000_0106);
    nreq         = 0;
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        pc_update = 1'b1;
        next_pc   = 32'h0000_0000;
      end
      step();
      pc_update = 1'b0;
      if (bus.imem_req) nreq++;
    end
    check("fault_noreq", nreq, 0);
    check("fault_pc", pc, 32'h0000_0106);
    check("fault_sticky", fetch_fault, 1'b1);
    check("fault_instret", instret, exp_instret);
    rst_n = 1'b0;
    step();
    reset_checks();
    exp_pc      = RST_PC;
    exp_instret = 32'h0;

    // 5: reset mid-fetch with a response on the reset cycle
    rst_n = 1'b1;
    step();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    check("t5_wait", bus.imem_req, 1'b0);
    rst_n           = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    reset_checks();
    rst_n = 1'b1;
    step();
    check("t5_valid", inst_valid, 1'b0);
    fetch(1, 0, 32'hCAFE_0001);

    // 6: wrap-around
    retire(32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    fetch(0, 1, 32'h0000_0073);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    retire(32'h0000_0000);
    check("wrap_instret", instret, 32'h0000_0000);
    check("wrap_plus4b", pc_plus4, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
